// File: rtl/noc_router_param.sv
// Five-port XY mesh router: a FIFO on every input and a one-flit register on every output.
// Each output has a round-robin arbiter, so a flit can move from an input head to an output register every cycle.
module noc_router_param #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*DATA_W-1:0]   in_data,
    input  logic [4:0]            in_valid,
    output logic [4:0]            in_ready,
    output logic [5*DATA_W-1:0]   out_data,
    output logic [4:0]            out_valid,
    input  logic [4:0]            out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]      FULL    = CW'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X    = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] MY_Y    = COORD_W'(Y_ID);
    localparam logic [2:0]         PTR_RST = 3'd4;

    logic [DATA_W-1:0] mem [5][DEPTH];
    logic [PW-1:0]     rd_ptr [5];
    logic [PW-1:0]     wr_ptr [5];
    logic [CW-1:0]     count [5];
    logic [DATA_W-1:0] head [5];
    logic [4:0]        nonempty;
    logic [4:0]        push;
    logic [4:0]        pop;
    logic [4:0]        route [5];
    logic [4:0]        req [5];
    logic [4:0]        can_load;
    logic [4:0]        any_grant;
    logic [4:0]        grant [5];
    logic [2:0]        gidx [5];
    logic [2:0]        rr_ptr [5];

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        logic [3:0] r;
        r = (v >= 4'd5) ? (v - 4'd5) : v;
        return r[2:0];
    endfunction

    // One-hot output port chosen by dimension-ordered routing: X first, then Y.
    function automatic logic [4:0] xy_route(input logic [2*COORD_W-1:0] hdr);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = hdr[COORD_W-1:0];
        dy = hdr[2*COORD_W-1:COORD_W];
        if (dx > MY_X)
            return 5'b00010;
        else if (dx < MY_X)
            return 5'b00100;
        else if (dy > MY_Y)
            return 5'b01000;
        else if (dy < MY_Y)
            return 5'b10000;
        else
            return 5'b00001;
    endfunction

    for (genvar p = 0; p < 5; p++) begin : g_in
        assign head[p]     = mem[p][rd_ptr[p]];
        assign nonempty[p] = |count[p];
        assign in_ready[p] = (count[p] < FULL) & ~rst;
        assign push[p]     = in_valid[p] & in_ready[p];
        assign route[p]    = xy_route(head[p][2*COORD_W-1:0]);
        assign pop[p]      = grant[0][p] | grant[1][p] | grant[2][p] | grant[3][p] | grant[4][p];
    end

    for (genvar o = 0; o < 5; o++) begin : g_req
        for (genvar p = 0; p < 5; p++) begin : g_src
            assign req[o][p] = nonempty[p] & route[p][o];
        end
        assign can_load[o] = ~out_valid[o] | out_ready[o];
    end

    // Search starts one past the last winner, so the previous winner gets the lowest priority.
    always_comb begin : arb
        logic [2:0] cand;
        logic       found;
        for (int o = 0; o < 5; o++) begin
            grant[o]     = '0;
            gidx[o]      = rr_ptr[o];
            found        = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                cand = wrap5(4'(rr_ptr[o]) + 4'(k));
                if (can_load[o] && !found && req[o][cand]) begin
                    grant[o][cand] = 1'b1;
                    gidx[o]        = cand;
                    found          = 1'b1;
                end
            end
            any_grant[o] = found;
        end
    end

    // Storage array has no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++) begin
            if (push[p])
                mem[p][wr_ptr[p]] <= in_data[p*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 5; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (push[p])
                    wr_ptr[p] <= wr_ptr[p] + PW'(1);
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + PW'(1);
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CW'(1);
                    2'b01:   count[p] <= count[p] - CW'(1);
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // Output registers keep their data after a transfer; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            for (int o = 0; o < 5; o++)
                rr_ptr[o] <= PTR_RST;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (any_grant[o]) begin
                    out_valid[o]                  <= 1'b1;
                    out_data[o*DATA_W +: DATA_W]  <= head[gidx[o]];
                    rr_ptr[o]                     <= gidx[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_router_param.sv
// Scoreboard bench for noc_router_param with router position (1,1): directed scenarios, then random traffic.
// A negedge monitor records accepted flits and compares every output transfer against them.
module tb_noc_router_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] in_data;
    logic [4:0]  in_valid;
    logic [4:0]  in_ready;
    logic [39:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;

    int checks   = 0;
    int failures = 0;
    bit ordered  = 1'b1;

    // Ordered mode: one expected stream per output. Random mode: one stream per (output, source tag).
    logic [7:0] q_ord [5][$];
    logic [7:0] q_src [25][$];

    logic [7:0] mon_got;
    logic [7:0] mon_exp;
    int         mon_s;
    int         mon_o;

    noc_router_param #(
        .DATA_W(8), .DEPTH(4), .COORD_W(2), .X_ID(1), .Y_ID(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Destination output for a flit at router (1,1), from the mesh rules.
    function automatic int route_of(input logic [7:0] f);
        int dx;
        int dy;
        dx = int'(f[1:0]);
        dy = int'(f[3:2]);
        if (dx > 1) return 1;
        if (dx < 1) return 2;
        if (dy > 1) return 3;
        if (dy < 1) return 4;
        return 0;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int o = 0; o < 5; o++) n += q_ord[o].size();
        for (int i = 0; i < 25; i++) n += q_src[i].size();
        return n;
    endfunction

    task compareValue(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task applyStimulus(input logic [4:0] v, input logic [39:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task checkOutput(input string name, input logic [4:0] exp_v);
        @(negedge clk);
        compareValue(name, 40'(out_valid), 40'(exp_v));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int o = 0; o < 5; o++) q_ord[o].delete();
            for (int i = 0; i < 25; i++) q_src[i].delete();
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    mon_got = out_data[o*8 +: 8];
                    if (ordered) begin
                        if (q_ord[o].size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL stray_out%0d got=%h expected=none", o, mon_got);
                        end else begin
                            mon_exp = q_ord[o].pop_front();
                            compareValue($sformatf("out%0d_data", o), 40'(mon_got), 40'(mon_exp));
                        end
                    end else begin
                        mon_s = int'(mon_got[7:5]);
                        if (mon_s > 4 || q_src[o*5+mon_s].size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL stray_out%0d got=%h expected=none", o, mon_got);
                        end else begin
                            mon_exp = q_src[o*5+mon_s].pop_front();
                            compareValue($sformatf("rand_out%0d_data", o), 40'(mon_got), 40'(mon_exp));
                        end
                    end
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    mon_got = in_data[p*8 +: 8];
                    mon_o   = route_of(mon_got);
                    if (ordered)
                        q_ord[mon_o].push_back(mon_got);
                    else
                        q_src[mon_o*5+p].push_back(mon_got);
                end
            end
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog_timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] stream [6];
    int         accepted;
    logic       acc;

    initial begin
        stream    = '{8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hE6, 8'hF6};
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        compareValue("reset_in_ready", 40'(in_ready), 40'(0));
        compareValue("reset_out_valid", 40'(out_valid), 40'(0));
        compareValue("reset_out_data", out_data, 40'(0));
        rst = 1'b0;
        #1;
        compareValue("release_in_ready", 40'(in_ready), 40'(5'h1F));
        compareValue("release_out_valid", 40'(out_valid), 40'(0));
        compareValue("release_out_data", out_data, 40'(0));
        @(posedge clk);
        #1;

        $display("[TB] single flit local->east");
        applyStimulus(5'b00001, 40'h00_00_00_00_A6);
        checkOutput("single_k", 5'b00000);
        checkOutput("single_k1", 5'b00010);
        checkOutput("single_k2", 5'b00000);

        $display("[TB] four-way contention for local output");
        for (int r = 0; r < 2; r++) begin
            if (r == 0)
                applyStimulus(5'b11101, {8'h85, 8'h65, 8'h45, 8'h00, 8'h05});
            else
                applyStimulus(5'b11101, {8'h95, 8'h75, 8'h55, 8'h00, 8'h15});
            checkOutput("burst_wait", 5'b00000);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("burst%0d_emit%0d", r, i), 5'b00001);
            checkOutput("burst_done", 5'b00000);
        end

        $display("[TB] backpressure on east output");
        out_ready = 5'b11101;
        accepted  = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 5'b00001;
            in_data  = 40'(stream[(accepted < 6) ? accepted : 5]);
            acc      = in_ready[0];
            @(posedge clk);
            #1;
            if (acc) accepted++;
        end
        compareValue("bp_accepted", 40'(accepted), 40'(5));
        compareValue("bp_full_ready", 40'(in_ready[0]), 40'(0));
        in_valid  = '0;
        out_ready = 5'h1F;
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("bp_drain%0d", i), 5'b00010);
        checkOutput("bp_drain_end", 5'b00000);

        $display("[TB] all five outputs in parallel");
        applyStimulus(5'h1F, {8'h35, 8'h01, 8'h36, 8'h0C, 8'h09});
        checkOutput("parallel_k", 5'b00000);
        checkOutput("parallel_k1", 5'h1F);
        checkOutput("parallel_k2", 5'b00000);

        $display("[TB] reset with flits buffered");
        out_ready = 5'b11101;
        applyStimulus(5'b00001, 40'h00_00_00_00_A6);
        applyStimulus(5'b00001, 40'h00_00_00_00_B6);
        applyStimulus(5'b00001, 40'h00_00_00_00_C6);
        compareValue("pre_rst_out_valid", 40'(out_valid), 40'(5'b00010));
        rst = 1'b1;
        #1;
        compareValue("mid_rst_out_valid", 40'(out_valid), 40'(0));
        compareValue("mid_rst_in_ready", 40'(in_ready), 40'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 5'h1F;
        #1;
        compareValue("post_rst_in_ready", 40'(in_ready), 40'(5'h1F));
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("post_rst_quiet%0d", i), 5'b00000);
        applyStimulus(5'b00100, 40'h00_00_36_00_00);
        checkOutput("post_rst_new_k", 5'b00000);
        checkOutput("post_rst_new_k1", 5'b00010);
        checkOutput("post_rst_new_k2", 5'b00000);
        compareValue("directed_drained", 40'(pending()), 40'(0));

        $display("[TB] random traffic");
        ordered = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid = 5'($urandom);
            for (int p = 0; p < 5; p++)
                in_data[p*8 +: 8] = {3'(p), 1'($urandom), 4'($urandom)};
            out_ready = 5'($urandom | $urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = '0;
        out_ready = 5'h1F;
        for (int w = 0; w < 200 && pending() > 0; w++) begin
            @(posedge clk);
            #1;
        end
        compareValue("random_drained", 40'(pending()), 40'(0));
        checkOutput("idle_after_drain", 5'b00000);
        compareValue("idle_in_ready", 40'(in_ready), 40'(5'h1F));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_router_param.md
NOC_ROUTER_PARAM -- requirements
Module: noc_router_param

Interface
REQ-001 Parameter DATA_W, default 8, flit width in bits.
REQ-002 Parameter DEPTH, default 4, per-input FIFO depth in flits; SHALL be a power of two, at least 2.
REQ-003 Parameter COORD_W, default 2, width of each destination coordinate.
REQ-004 Parameter X_ID, default 0, this router's X coordinate.
REQ-005 Parameter Y_ID, default 0, this router's Y coordinate.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_data  in  5*DATA_W  input flits; port p occupies bits [p*DATA_W +: DATA_W]; ports 0=Local, 1=East, 2=West, 3=North, 4=South.
REQ-009 in_valid  in  5  per-input flit-present flags.
REQ-010 in_ready  out  5  per-input accept flags.
REQ-011 out_data  out  5*DATA_W  output flits, same port packing as in_data.
REQ-012 out_valid  out  5  per-output flit-present flags.
REQ-013 out_ready  in  5  per-output downstream accept flags.

Function
REQ-014 Flit header: destination X = flit[COORD_W-1:0], destination Y = flit[2*COORD_W-1:COORD_W]; every flit is a single-flit packet.
REQ-015 Each input SHALL have a DEPTH-entry FIFO with a count register of clog2(DEPTH)+1 bits; write on in_valid&in_ready; read pointer and write pointer wrap modulo DEPTH.
REQ-016 in_ready[p] = (count<DEPTH) & ~rst; it SHALL NOT depend combinationally on out_ready or on a same-cycle pop.
REQ-017 Simultaneous push and pop on the same FIFO SHALL leave the count unchanged and SHALL preserve order.
REQ-018 Route for the FIFO head uses XY routing: dx>X_ID -> East; dx<X_ID -> West; else dy>Y_ID -> North; dy<Y_ID -> South; else Local.
REQ-019 Each output SHALL have a one-flit output register (out_data, out_valid) that may load when out_valid==0 or out_ready==1.
REQ-020 Each output SHALL have a round-robin arbiter with a 3-bit pointer to the last granted input; the search starts at pointer+1 mod 5 over non-empty inputs routed to that output.
REQ-021 A grant SHALL be issued only when the output register may load; on a grant the output register loads the head flit, the input FIFO pops, and the pointer updates to the granted index, all on the same edge.
REQ-022 With no grant, the pointer SHALL hold, and the output register SHALL hold, or SHALL clear out_valid if out_ready==1.
REQ-023 Latency: a flit accepted at edge k with no contention SHALL show out_valid high from edge k+1.
REQ-024 Outputs with disjoint request sets SHALL transfer in parallel in the same cycle; there is no throughput coupling between outputs.
REQ-025 Each input SHALL be granted by at most one output per cycle (guaranteed by single-route XY), and flits SHALL never be dropped or duplicated.
REQ-026 Sustained throughput per output SHALL be one flit per cycle while out_ready==1 and requests are pending.

Reset
REQ-027 While rst is high: all FIFO counts and pointers are 0, in_ready=5'b00000, out_valid=5'b00000, out_data all zeros, and every arbiter pointer is 4, giving input 0 first priority.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and registered flits immediately; after rst falls, in_ready=5'b11111 and no stale flit appears.

Verification (DATA_W=8, DEPTH=4, COORD_W=2, X_ID=1, Y_ID=1)
REQ-029 Release rst -> in_ready=5'h1F, out_valid=5'h00, out_data=0.
REQ-030 Port 0 sends 8'hA6 (dest 2,1) once with out_ready=5'h1F -> out_valid[1] high one cycle after the accept edge, data 8'hA6, single cycle.
REQ-031 Ports 0, 2, 3 and 4 each send 8'h35 (Local) in the same cycle, with out_ready[0]=1 -> output 0 emits from inputs 0, 2, 3, 4 in that order on consecutive cycles; a repeat burst is also granted in order 0, 2, 3, 4.
REQ-032 out_ready[1]=0; port 0 streams 8'hA6, 8'hB6, 8'hC6, ... -> 5 flits accepted, then in_ready[0]=0; after out_ready[1]=1, the 5 flits exit in order with no gaps or loss.
REQ-033 In one cycle, port 0 sends 8'h09 (North), port 1 sends 8'h0C (West), port 2 sends 8'h36 (East), port 3 sends 8'h01 (South) and port 4 sends 8'h35 (Local) -> all five out_valid bits high on the same cycle, each output carrying the correct flit.
REQ-034 With two flits held in FIFOs, assert rst for 1 cycle -> out_valid=0 at once; after release, no output activity until new input arrives.
